// File: rtl/mp_add_seq_pkg.sv
// Shared types and defaults for the multi-precision add/subtract sequencer.
package mp_add_seq_pkg;

  localparam int WORD_DEF   = 16;
  localparam int NWORDS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mp_add_seq_if.sv
// Request/result bundle of mp_add_seq. The master drives start and operands;
// the slave returns status, result and its current FSM state for observation.
interface mp_add_seq_if
  import mp_add_seq_pkg::*;
#(
  parameter int WORD   = WORD_DEF,
  parameter int NWORDS = NWORDS_DEF
);
  localparam int W = WORD * NWORDS;

  // start is a request pulse; it is taken only while busy is low, and done
  // marks the single cycle in which a new result first becomes valid.
  logic         start;
  logic         sub;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  state_t       dbg_state;

  modport master (
    output start, sub, opa, opb,
    input  busy, done, result, cout, ovf, dbg_state
  );

  modport slave (
    input  start, sub, opa, opb,
    output busy, done, result, cout, ovf, dbg_state
  );
endinterface

// File: rtl/mp_add_seq_adder.sv
// Plain combinational ripple adder slice with carry in and carry out.
module adder #(
  parameter int size = 16
) (
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  input  logic            cin,
  output logic [size-1:0] sum,
  output logic            cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{size{1'b0}}, cin};
endmodule

// File: rtl/mp_add_seq.sv
// Wide add/subtract computed one WORD-bit slice per cycle through a single
// shared adder, least significant slice first, with the carry registered.
module mp_add_seq
  import mp_add_seq_pkg::*;
#(
  parameter int WORD   = WORD_DEF,
  parameter int NWORDS = NWORDS_DEF,
  parameter int IW     = 2
) (
  input  logic           clk,
  input  logic           rst,
  mp_add_seq_if.slave    bus
);
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  state_t                       state;
  logic [IW-1:0]                idx;
  logic                         carry;
  logic [NWORDS-1:0][WORD-1:0]  a_q;
  logic [NWORDS-1:0][WORD-1:0]  b_q;
  logic [NWORDS-1:0][WORD-1:0]  result_q;
  logic                         cout_q;
  logic                         ovf_q;
  logic                         busy_q;
  logic                         done_q;
  logic [WORD-1:0]              sum;
  logic                         slice_cout;

  adder #(.size(WORD)) u_adder (
    .a    (a_q[idx]),
    .b    (b_q[idx]),
    .cin  (carry),
    .sum  (sum),
    .cout (slice_cout)
  );

  // b_q holds the already-inverted operand for subtraction, so the overflow
  // test below is the plain same-sign-in, different-sign-out rule.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q      <= bus.opa;
            b_q      <= bus.sub ? ~bus.opb : bus.opb;
            carry    <= bus.sub;
            idx      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b1;
            state    <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          result_q[idx] <= sum;
          carry         <= slice_cout;
          idx           <= idx + 1'b1;
          if (idx == LAST) begin
            cout_q <= slice_cout;
            ovf_q  <= (a_q[NWORDS-1][WORD-1] == b_q[NWORDS-1][WORD-1]) &&
                      (sum[WORD-1] != a_q[NWORDS-1][WORD-1]);
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbg_state = state;

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer for the SAYAC datapath.
- Computes an NWORDS×WORD-bit sum or difference by time-multiplexing one WORD-bit `adder` instance, one word slice per cycle, least significant slice first.
- The slice carry-out is registered and chained into the next slice's carry-in.
- Used wherever operands wider than the native adder are needed, without instantiating a wide adder.

Parameters:
- WORD, 16, width of the shared adder slice in bits.
- NWORDS, 4, number of slices; total operand width W = WORD*NWORDS.
- IW, 2, width of the slice index counter; must satisfy 2**IW >= NWORDS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when the block can accept (IDLE or DONE).
- sub  input  1  0 = A+B, 1 = A−B; sampled with start.
- opa  input  W  operand A; sampled with start.
- opb  input  W  operand B; sampled with start.
- busy  output  1  high while slices are being computed (RUN).
- done  output  1  one-cycle pulse; result, cout and ovf are valid from this cycle on.
- result  output  W  sum or difference; held until the next accepted start.
- cout  output  1  final carry out. For subtraction, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow of the full W-bit operation.

Behaviour:
- Reset is synchronous, active-high, and has priority over all other inputs. State = IDLE, busy=0, done=0, result=0, cout=0, ovf=0, index=0, carry=0, operand registers cleared.
- States: IDLE, RUN, DONE.
- Transitions:
  - IDLE -> RUN on start.
  - RUN -> RUN while index < NWORDS−1.
  - RUN -> DONE after the slice with index NWORDS−1.
  - DONE -> RUN if start is high; otherwise DONE -> IDLE.
- Accept, in IDLE or DONE with start=1:
  - Latch A = opa.
  - Latch B = sub ? ~opb : opb.
  - carry = sub, index = 0.
  - Clear result, cout and ovf.
  - Go to RUN.
- Each RUN cycle:
  - adder a = A slice[index], b = B slice[index], cin = carry.
  - result slice[index] <= sum; carry <= adder cout; index <= index+1.
- Last slice (index = NWORDS−1):
  - cout <= adder cout.
  - ovf <= (A[W−1] == B'[W−1]) && (sum[WORD−1] != A[W−1]), where B' is the latched, possibly inverted B.
- busy = 1 exactly in RUN. It is a registered state decode with no combinational path from start.
- done = 1 exactly in DONE, for one cycle per operation.
- Latency: start accepted at edge t -> NWORDS RUN cycles -> done high in the cycle after edge t+NWORDS. This is 5 cycles at the defaults.
- Throughput: one operation per NWORDS+1 cycles, including back-to-back accept from DONE.
- start in RUN is ignored. No queuing and no error flag; the operands and sub presented at that time are discarded.
- opa, opb and sub may change freely after the accepting edge; only the latched copies are used.
- In DONE with start=1:
  - done still pulses in that cycle.
  - The old result is visible during that cycle and is cleared at the next edge.
- rst in RUN: the operation is aborted, done never pulses, and all outputs take their reset values at that edge.
- Arithmetic wraps modulo 2**W; there is no saturation.
- Subtraction semantics: A + ~B + 1, with cout = 1 when A >= B unsigned.
- The adder instance is purely combinational. The critical path is index mux -> adder -> slice register.

Decomposition:
- Shared package:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default WORD/NWORDS values.
- Sub-module: exactly one instance of the existing `adder`, with size = WORD.
- Slice select/write logic stays in this module. A separate slice-mux module is not warranted.

Test Plan:
- Reset: assert rst 2 cycles mid-stream -> busy=0, done=0, result=0, cout=0, ovf=0 on the cycle after the edge.
- Inter-slice carry: opa=0x0000_0000_0000_FFFF, opb=0x1, sub=0 -> done at start+5, result=0x0000_0000_0001_0000, cout=0, ovf=0; busy high exactly 4 cycles.
- Full ripple: opa=0xFFFF_FFFF_FFFF_FFFF, opb=0x1, sub=0 -> result=0, cout=1, ovf=0.
- Subtract/borrow:
  - opa=5, opb=7, sub=1 -> result=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
  - Then opa=0x7FFF_FFFF_FFFF_FFFF, opb=0x1, sub=0 -> result=0x8000_0000_0000_0000, ovf=1, cout=0.
- Handshake boundaries:
  - start pulsed during RUN with different operands -> ignored, first result unchanged.
  - start held high in the DONE cycle -> second op accepted, second done exactly 5 cycles after the first.
- Abort: rst asserted in the 3rd RUN cycle -> done never pulses, IDLE next cycle. A following op 3+4 gives result=7 at start+5.
